// File: rtl/pwf_pkg.sv
// Shared types, default parameters and helpers for the pulse-width scheduler.
package pwf_pkg;

  localparam int unsigned N_CH_DEF      = 4;
  localparam int unsigned MIN_WIDTH_DEF = 12;
  localparam int unsigned WW_DEF        = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    REPORT  = 2'd2
  } state_e;

  // Channel index k steps after ptr+1, wrapped into 0..n-1 (ptr, k < n).
  function automatic int unsigned rr_index(int unsigned ptr, int unsigned k, int unsigned n);
    int unsigned s;
    s = ptr + 1 + k;
    return (s >= n) ? (s - n) : s;
  endfunction

endpackage

// File: rtl/pwf_sched_if.sv
// Event handshake bus from the scheduler to its consumer.
interface pwf_sched_if
  import pwf_pkg::*;
#(
  parameter int unsigned N_CH = N_CH_DEF,
  parameter int unsigned WW   = WW_DEF
) ();

  localparam int unsigned CW = $clog2(N_CH > 1 ? N_CH : 2);

  logic          ev_valid;
  logic          ev_ready;
  logic [CW-1:0] ev_ch;
  logic [WW-1:0] ev_width;

  modport master (output ev_valid, output ev_ch, output ev_width, input ev_ready);
  modport slave  (input ev_valid, input ev_ch, input ev_width, output ev_ready);

endinterface

// File: rtl/pwf_rr_arb.sv
// Combinational round-robin picker: first eligible channel after rr_ptr.
module pwf_rr_arb
  import pwf_pkg::*;
#(
  parameter int unsigned N_CH = N_CH_DEF,
  localparam int unsigned CW  = $clog2(N_CH > 1 ? N_CH : 2)
) (
  input  logic [N_CH-1:0] eligible,
  input  logic [CW-1:0]   rr_ptr,
  output logic            gnt_valid,
  output logic [CW-1:0]   gnt_idx
);

  // Scan from the farthest candidate back to the nearest so the nearest wins.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    for (int unsigned k = 0; k < N_CH; k++) begin
      if (eligible[CW'(rr_index(32'(rr_ptr), N_CH - 1 - k, N_CH))]) begin
        gnt_valid = 1'b1;
        gnt_idx   = CW'(rr_index(32'(rr_ptr), N_CH - 1 - k, N_CH));
      end
    end
  end

endmodule

// File: rtl/pwf_sched.sv
// Multi-channel pulse-width qualifier: picks one armed channel at a time,
// measures its high time with a shared counter and reports qualified pulses.
module pwf_sched
  import pwf_pkg::*;
#(
  parameter int unsigned N_CH      = N_CH_DEF,
  parameter int unsigned MIN_WIDTH = MIN_WIDTH_DEF,
  parameter int unsigned WW        = WW_DEF
) (
  input  logic            clk4m,
  input  logic            rst_n,
  input  logic [N_CH-1:0] a,
  pwf_sched_if.master     ev,
  output logic            c,
  output logic            rej,
  output logic            busy
);

  localparam int unsigned CW      = $clog2(N_CH > 1 ? N_CH : 2);
  localparam logic [WW-1:0] CNT_MAX = '1;
  localparam logic [WW-1:0] MIN_W   = WW'(MIN_WIDTH);

  state_e          state_q, state_d;
  logic [WW-1:0]   cnt_q, cnt_d;
  logic [CW-1:0]   cur_ch_q, cur_ch_d;
  logic [CW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [CW-1:0]   ev_ch_q, ev_ch_d;
  logic [WW-1:0]   ev_width_q, ev_width_d;
  logic [N_CH-1:0] armed_q, armed_d;
  logic            ev_valid_q;
  logic            rej_d, c_d;
  logic [N_CH-1:0] eligible;
  logic            gnt_valid, grant;
  logic [CW-1:0]   gnt_idx;
  logic            a_cur;

  assign eligible = a & armed_q;
  assign grant    = (state_q == IDLE) && gnt_valid;
  assign a_cur    = a[cur_ch_q];

  assign ev.ev_valid = ev_valid_q;
  assign ev.ev_ch    = ev_ch_q;
  assign ev.ev_width = ev_width_q;

  pwf_rr_arb #(.N_CH(N_CH)) u_arb (
    .eligible  (eligible),
    .rr_ptr    (rr_ptr_q),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx)
  );

  // Next-state, arming and event-latch logic.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    cur_ch_d   = cur_ch_q;
    rr_ptr_d   = rr_ptr_q;
    ev_ch_d    = ev_ch_q;
    ev_width_d = ev_width_q;
    armed_d    = armed_q;
    rej_d      = 1'b0;

    // A line must be seen low before it can be granted; any high line is
    // disarmed while busy or when some channel wins in IDLE.
    for (int unsigned i = 0; i < N_CH; i++) begin
      if (!a[i]) begin
        armed_d[i] = 1'b1;
      end else if ((state_q != IDLE) || grant) begin
        armed_d[i] = 1'b0;
      end
    end

    case (state_q)
      IDLE: begin
        if (grant) begin
          state_d  = MEASURE;
          cur_ch_d = gnt_idx;
          rr_ptr_d = gnt_idx;
          cnt_d    = WW'(1);
        end
      end
      MEASURE: begin
        if (a_cur) begin
          cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + WW'(1);
        end else if (cnt_q >= MIN_W) begin
          state_d    = REPORT;
          ev_ch_d    = cur_ch_q;
          ev_width_d = cnt_q;
        end else begin
          state_d = IDLE;
          rej_d   = 1'b1;
        end
      end
      REPORT: begin
        if (ev.ev_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    c_d = (state_d == MEASURE) && (cnt_d >= MIN_W);
  end

  // State and registered outputs.
  always_ff @(posedge clk4m or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      cur_ch_q   <= '0;
      rr_ptr_q   <= CW'(N_CH - 1);
      armed_q    <= '0;
      ev_ch_q    <= '0;
      ev_width_q <= '0;
      ev_valid_q <= 1'b0;
      c          <= 1'b0;
      rej        <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cur_ch_q   <= cur_ch_d;
      rr_ptr_q   <= rr_ptr_d;
      armed_q    <= armed_d;
      ev_ch_q    <= ev_ch_d;
      ev_width_q <= ev_width_d;
      ev_valid_q <= (state_d == REPORT);
      c          <= c_d;
      rej        <= rej_d;
      busy       <= (state_d != IDLE);
    end
  end

endmodule
